// File: rtl/prng_lfsr.sv
// Purpose: Fibonacci LFSR pseudo-random word generator with seed load and period detection.
// Latency: out_data is the state register itself; each accepted word advances STEP shifts at the next edge.
// Backpressure: out_valid/out_ready handshake; the state holds while out_valid is high and out_ready is low.
module prng_lfsr #(
  parameter int              WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
  parameter int              STEP       = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             enable,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] xfer_cnt,
  output logic             period_hit,
  output logic             seed_err
);

  // STEP single shifts chained combinationally; the loop unrolls into one
  // XOR network so a multi-shift advance still completes in one cycle.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] v;
    v = cur;
    for (int k = 0; k < STEP; k++) begin
      v = {v[WIDTH-2:0], ^(v & TAPS)};
    end
    return v;
  endfunction

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] cnt_q;
  logic             hit_q;
  logic             err_q;

  logic             load_en;
  logic             transfer;
  logic             zero_seed;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] adv_val;
  logic             cnt_full;

  // A load cycle never presents a word, so the load always wins over a transfer.
  assign out_valid = enable & ~seed_load;
  assign out_data  = state_q;
  assign xfer_cnt  = cnt_q;
  assign period_hit = hit_q;
  assign seed_err  = err_q;

  // Loads are gated by enable so a disabled generator stays fully frozen.
  assign load_en   = enable & seed_load;
  assign transfer  = out_valid & out_ready;
  assign zero_seed = (seed_data == '0);
  // An all-zero seed would lock the LFSR at zero forever, so substitute the reset seed.
  assign load_val  = zero_seed ? RESET_SEED : seed_data;
  assign adv_val   = advance(state_q);
  assign cnt_full  = &cnt_q;

  // State register: load, advance on accepted word, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_SEED;
    end else if (load_en) begin
      state_q <= load_val;
    end else if (transfer) begin
      state_q <= adv_val;
    end
  end

  // Active seed: the value a full period returns to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= RESET_SEED;
    end else if (load_en) begin
      seed_q <= load_val;
    end
  end

  // Transfer counter since last load, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_en) begin
      cnt_q <= '0;
    end else if (transfer && !cnt_full) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // One-cycle pulse after the transfer that lands back on the active seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= transfer && (adv_val == seed_q);
    end
  end

  // Sticky zero-seed flag, rewritten by every load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (load_en) begin
      err_q <= zero_seed;
    end
  end

endmodule

// File: tb/tb_prng_lfsr.sv
// Bench for prng_lfsr: a STEP=1 and a STEP=16 instance driven by shared stimulus,
// each checked every cycle against a word-level model, plus literal spot checks.
module tb_prng_lfsr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_data = 16'h0;
  logic        enable = 1'b0;
  logic        out_ready = 1'b0;

  logic        o_valid [2];
  logic [15:0] o_data  [2];
  logic [15:0] o_cnt   [2];
  logic        o_hit   [2];
  logic        o_err   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prng_lfsr #(.WIDTH(16), .TAPS(16'hB400), .STEP(1), .RESET_SEED(16'h0001)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_data(seed_data),
    .enable(enable), .out_ready(out_ready), .out_valid(o_valid[0]),
    .out_data(o_data[0]), .xfer_cnt(o_cnt[0]), .period_hit(o_hit[0]), .seed_err(o_err[0])
  );

  prng_lfsr #(.WIDTH(16), .TAPS(16'hB400), .STEP(16), .RESET_SEED(16'h0001)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_data(seed_data),
    .enable(enable), .out_ready(out_ready), .out_valid(o_valid[1]),
    .out_data(o_data[1]), .xfer_cnt(o_cnt[1]), .period_hit(o_hit[1]), .seed_err(o_err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Word-level reference: parity of tapped bits enters at bit 0, n shifts.
  function automatic logic [15:0] step_n(input logic [15:0] s, input int n);
    int v;
    int fb;
    v = s;
    for (int i = 0; i < n; i++) begin
      fb = $countones(v & 32'hB400) % 2;
      v  = ((v << 1) | fb) & 32'hFFFF;
    end
    return v[15:0];
  endfunction

  // Model state per instance (index 0: STEP=1, index 1: STEP=16).
  logic [15:0] m_state [2] = '{16'h0001, 16'h0001};
  logic [15:0] m_seed  [2] = '{16'h0001, 16'h0001};
  logic [15:0] m_cnt   [2] = '{16'h0000, 16'h0000};
  logic        m_hit   [2] = '{1'b0, 1'b0};
  logic        m_err   [2] = '{1'b0, 1'b0};
  int          steps   [2] = '{1, 16};

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] nxt;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_state[k] = 16'h0001; m_seed[k] = 16'h0001; m_cnt[k] = 0;
        m_hit[k] = 1'b0; m_err[k] = 1'b0;
      end else if (enable && seed_load) begin
        m_state[k] = (seed_data == 0) ? 16'h0001 : seed_data;
        m_seed[k]  = m_state[k];
        m_cnt[k]   = 0;
        m_err[k]   = (seed_data == 0);
        m_hit[k]   = 1'b0;
      end else if (enable && out_ready) begin
        nxt        = step_n(m_state[k], steps[k]);
        m_hit[k]   = (nxt == m_seed[k]);
        m_state[k] = nxt;
        if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 1;
      end else begin
        m_hit[k] = 1'b0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  int zero_seen = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.out_valid", k), o_valid[k], enable & ~seed_load);
      chk($sformatf("u%0d.out_data", k), o_data[k], m_state[k]);
      chk($sformatf("u%0d.xfer_cnt", k), o_cnt[k], m_cnt[k]);
      chk($sformatf("u%0d.period_hit", k), o_hit[k], m_hit[k]);
      chk($sformatf("u%0d.seed_err", k), o_err[k], m_err[k]);
      if (o_data[k] == 16'h0) zero_seen++;
    end
  end

  int first_hit;
  logic [15:0] held;

  initial begin
    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("rst out_data", o_data[0], 16'h0001);
    chk("rst xfer_cnt", o_cnt[0], 16'h0000);
    chk("rst seed_err", o_err[0], 1'b0);
    chk("rst period_hit", o_hit[0], 1'b0);

    // Load ACE1 with out_ready high: load wins, nothing presented.
    #1 rst_n = 1'b1; enable = 1'b1; seed_load = 1'b1; seed_data = 16'hACE1; out_ready = 1'b1;
    @(negedge clk);
    chk("load out_valid", o_valid[0], 1'b0);
    chk("load word0", o_data[0], 16'hACE1);
    chk("load cnt0", o_cnt[0], 16'h0000);
    chk("load no hit", o_hit[0], 1'b0);
    #1 seed_load = 1'b0;
    @(negedge clk);
    chk("word1", o_data[0], 16'h59C3);
    chk("cnt1", o_cnt[0], 16'h0001);
    chk("step16 word1", o_data[1], step_n(16'hACE1, 16));
    @(negedge clk);
    chk("word2", o_data[0], 16'hB387);
    chk("cnt2", o_cnt[0], 16'h0002);
    chk("step16 word2", o_data[1], step_n(16'hACE1, 32));

    // Stall for 5 cycles, then resume without skipping.
    #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall data", o_data[0], 16'hB387);
      chk("stall cnt", o_cnt[0], 16'h0002);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("resume word3", o_data[0], step_n(16'hB387, 1));
    chk("resume cnt3", o_cnt[0], 16'h0003);

    // Zero seed substitution, then a nonzero load clears the flag.
    #1 seed_load = 1'b1; seed_data = 16'h0000;
    @(negedge clk);
    chk("zero seed data", o_data[0], 16'h0001);
    chk("zero seed err", o_err[0], 1'b1);
    #1 seed_data = 16'h1234;
    @(negedge clk);
    chk("reload data", o_data[0], 16'h1234);
    chk("reload err", o_err[0], 1'b0);
    chk("reload cnt", o_cnt[0], 16'h0000);

    // Enable low freezes everything.
    #1 seed_load = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frozen data", o_data[0], 16'h1234);
      chk("frozen valid", o_valid[0], 1'b0);
    end

    // Randomized traffic with one asynchronous reset pulse mid-run.
    for (int c = 0; c < 3000; c++) begin
      #1;
      enable    = ($urandom_range(0, 99) < 85);
      seed_load = enable && ($urandom_range(0, 99) < 5);
      seed_data = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      if (c == 1500) begin
        #3 rst_n = 1'b0;
        #1;
        chk("async rst u1", o_data[0], 16'h0001);
        chk("async rst u16", o_data[1], 16'h0001);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
      end
    end

    // Full period from ACE1 with continuous transfers.
    #1 enable = 1'b1; seed_load = 1'b1; seed_data = 16'hACE1; out_ready = 1'b1;
    @(negedge clk);
    #1 seed_load = 1'b0;
    zero_seen = 0;
    first_hit = 0;
    for (int i = 1; i <= 65540; i++) begin
      @(negedge clk);
      if (o_hit[0] && first_hit == 0) first_hit = i;
      if (i == 65535) begin
        chk("cnt at 65535", o_cnt[0], 16'hFFFF);
        held = o_data[0];
      end
    end
    chk("first period_hit transfer", first_hit, 65535);
    chk("cnt saturated", o_cnt[0], 16'hFFFF);
    chk("zero words seen", zero_seen, 0);
    chk("period word is seed", held, 16'hACE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
